anomaly_alert_fsm: RTL and testbench



---
 rtl/anomaly_alert_fsm.sv | 190 +++++++++++++++++++
 tb/tb_anomaly_alert_fsm.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/anomaly_alert_fsm.sv
// Anomaly alert scorer: thresholds each feature window into a 0..9 score and a dominant
// class, then runs a debounced alert FSM with hold, acknowledge and cooldown.
module anomaly_alert_fsm #(
    parameter int PCHG_TH    = 48,
    parameter int DRIFT_TH   = 24,
    parameter int VOLR_TH    = 128,
    parameter int VOLA_TH    = 64,
    parameter int ARR_TH     = 200,
    parameter int SCORE_ON   = 3,
    parameter int SCORE_OFF  = 1,
    parameter int SCORE_CRIT = 6,
    parameter int HOLD_WIN   = 4,
    parameter int COOL_WIN   = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] features,
    input  logic         feature_valid,
    input  logic         alert_ack,
    output logic [3:0]   score,
    output logic [1:0]   alert_level,
    output logic [2:0]   alert_class,
    output logic         alert_pulse,
    output logic         alert_active,
    output logic [7:0]   event_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_ALERT = 2'd2,
        S_COOL  = 2'd3
    } state_t;

    localparam logic [3:0] LP_ON   = 4'(SCORE_ON);
    localparam logic [3:0] LP_OFF  = 4'(SCORE_OFF);
    localparam logic [3:0] LP_CRIT = 4'(SCORE_CRIT);
    localparam logic [3:0] LP_HOLD = 4'(HOLD_WIN);
    localparam logic [7:0] LP_COOL = 8'(COOL_WIN);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [7:0] w_b0, w_b1, w_b3, w_b5, w_b6, w_b7;
    logic       w_f0, w_f1, w_f3, w_f5, w_f6, w_f7;
    logic [3:0] w_score;
    logic [2:0] w_class;
    logic       w_unused;

    assign w_b0 = features[7:0];
    assign w_b1 = features[15:8];
    assign w_b3 = features[31:24];
    assign w_b5 = features[47:40];
    assign w_b6 = features[55:48];
    assign w_b7 = features[63:56];
    assign w_unused = ^{features[127:64], features[39:32], features[23:16]};

    assign w_f0 = w_b0 >= 8'(PCHG_TH);
    assign w_f1 = w_b1 >= 8'(DRIFT_TH);
    assign w_f3 = w_b3 >= 8'(VOLR_TH);
    assign w_f5 = (w_b5 == 8'h00) || (w_b5 == 8'hFF);
    assign w_f6 = w_b6 >= 8'(VOLA_TH);
    assign w_f7 = w_b7 >= 8'(ARR_TH);

    assign w_score = {2'b00, w_f0, 1'b0} + {3'b000, w_f1} + {2'b00, w_f3, 1'b0}
                   + {3'b000, w_f5} + {2'b00, w_f6, 1'b0} + {3'b000, w_f7};

    always_comb begin
        w_class = 3'd0;
        if (w_f0 && w_f3)  w_class = 3'd1;
        else if (w_f6)     w_class = 3'd2;
        else if (w_f3)     w_class = 3'd3;
        else if (w_f5)     w_class = 3'd4;
        else if (w_f7)     w_class = 3'd5;
    end

    // Stage 1: window score, candidate class and window strobe
    logic [3:0] r_score_p1;
    logic [2:0] r_class_p1;
    logic       r_vld_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_score_p1 <= 4'd0;
            r_class_p1 <= 3'd0;
            r_vld_p1   <= 1'b0;
        end else begin
            r_vld_p1 <= feature_valid;
            if (feature_valid) begin
                r_score_p1 <= w_score;
                r_class_p1 <= w_class;
            end
        end
    end

    // Stage 2: alert state machine
    state_t     r_state, w_state_n;
    logic [3:0] r_hold, w_hold_n;
    logic [7:0] r_cool, w_cool_n;
    logic [2:0] r_class_lat, w_class_n;
    logic [7:0] r_event, w_event_n;
    logic       r_pulse, w_pulse_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_hold      <= 4'd0;
            r_cool      <= 8'd0;
            r_class_lat <= 3'd0;
            r_event     <= 8'd0;
            r_pulse     <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_hold      <= w_hold_n;
            r_cool      <= w_cool_n;
            r_class_lat <= w_class_n;
            r_event     <= w_event_n;
            r_pulse     <= w_pulse_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_hold_n  = r_hold;
        w_cool_n  = r_cool;
        w_class_n = r_class_lat;
        w_event_n = r_event;
        w_pulse_n = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_vld_p1 && (r_score_p1 >= LP_ON)) w_state_n = S_ARMED;
            end
            S_ARMED: begin
                if (r_vld_p1) begin
                    if (r_score_p1 >= LP_ON) begin
                        w_state_n = S_ALERT;
                        w_pulse_n = 1'b1;
                        w_class_n = r_class_p1;
                        w_event_n = sat_inc8(r_event);
                        w_hold_n  = 4'd0;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end
            end
            S_ALERT: begin
                // Acknowledge takes priority; a coincident window is dropped.
                if (alert_ack) begin
                    w_state_n = S_COOL;
                    w_cool_n  = 8'd0;
                end else if (r_vld_p1) begin
                    if (r_score_p1 <= LP_OFF) begin
                        if (r_hold + 4'd1 == LP_HOLD) begin
                            w_state_n = S_COOL;
                            w_cool_n  = 8'd0;
                        end else begin
                            w_hold_n = r_hold + 4'd1;
                        end
                    end else begin
                        w_hold_n = 4'd0;
                    end
                end
            end
            S_COOL: begin
                if (r_vld_p1) begin
                    if (r_cool + 8'd1 == LP_COOL) w_state_n = S_IDLE;
                    else                          w_cool_n  = r_cool + 8'd1;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_comb begin
        alert_level = 2'd0;
        case (r_state)
            S_ARMED: alert_level = 2'd1;
            S_ALERT: alert_level = (r_score_p1 >= LP_CRIT) ? 2'd3 : 2'd2;
            default: alert_level = 2'd0;
        endcase
    end

    assign score        = r_score_p1;
    assign alert_class  = r_class_lat;
    assign alert_pulse  = r_pulse;
    assign alert_active = (r_state == S_ALERT);
    assign event_count  = r_event;

endmodule

// File: tb/tb_anomaly_alert_fsm.sv
// Bench for anomaly_alert_fsm: directed scenarios plus a randomized full-rate run, all
// checked against a window-level behavioural model of the alert rules.
module tb_anomaly_alert_fsm;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] features;
    logic         feature_valid;
    logic         alert_ack;
    logic [3:0]   score;
    logic [1:0]   alert_level;
    logic [2:0]   alert_class;
    logic         alert_pulse;
    logic         alert_active;
    logic [7:0]   event_count;
    logic [18:0]  obs;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    anomaly_alert_fsm dut (
        .clk          (clk),
        .rst          (rst),
        .features     (features),
        .feature_valid(feature_valid),
        .alert_ack    (alert_ack),
        .score        (score),
        .alert_level  (alert_level),
        .alert_class  (alert_class),
        .alert_pulse  (alert_pulse),
        .alert_active (alert_active),
        .event_count  (event_count)
    );

    assign obs = {score, alert_level, alert_class, alert_pulse, alert_active, event_count};

    // Model: mode 0 idle, 1 armed, 2 alert, 3 cooldown
    int m_mode, m_hold, m_cool, m_event, m_entries, m_cls, m_pulse;
    int m_pvld, m_pscore, m_pcls;

    function automatic int byte_of(input logic [127:0] f, input int k);
        return int'(f[8*k +: 8]);
    endfunction

    function automatic int ref_score(input logic [127:0] f);
        int s = 0;
        if (byte_of(f, 0) >= 48)  s += 2;
        if (byte_of(f, 1) >= 24)  s += 1;
        if (byte_of(f, 3) >= 128) s += 2;
        if (byte_of(f, 5) == 0 || byte_of(f, 5) == 255) s += 1;
        if (byte_of(f, 6) >= 64)  s += 2;
        if (byte_of(f, 7) >= 200) s += 1;
        return s;
    endfunction

    function automatic int ref_class(input logic [127:0] f);
        bit p0 = byte_of(f, 0) >= 48;
        bit p3 = byte_of(f, 3) >= 128;
        bit p5 = byte_of(f, 5) == 0 || byte_of(f, 5) == 255;
        if (p0 && p3) return 1;
        if (byte_of(f, 6) >= 64) return 2;
        if (p3) return 3;
        if (p5) return 4;
        if (byte_of(f, 7) >= 200) return 5;
        return 0;
    endfunction

    function automatic logic [127:0] mk(input int b0, b1, b3, b5, b6, b7);
        logic [127:0] f;
        f[127:96] = $urandom;
        f[95:64]  = $urandom;
        f[63:56]  = 8'(b7);
        f[55:48]  = 8'(b6);
        f[47:40]  = 8'(b5);
        f[39:32]  = 8'($urandom);
        f[31:24]  = 8'(b3);
        f[23:16]  = 8'($urandom);
        f[15:8]   = 8'(b1);
        f[7:0]    = 8'(b0);
        return f;
    endfunction

    function automatic logic [127:0] quiet();
        return mk(16, 16, 16, 128, 16, 16);
    endfunction

    function automatic logic [127:0] s9();
        return mk(255, 255, 255, 0, 255, 255);
    endfunction

    function automatic logic [18:0] exp_vec();
        int lvl;
        lvl = (m_mode == 2) ? ((m_pscore >= 6) ? 3 : 2) : ((m_mode == 1) ? 1 : 0);
        return {4'(m_pscore), 2'(lvl), 3'(m_cls), 1'(m_pulse), 1'(m_mode == 2), 8'(m_event)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_hold = 0; m_cool = 0; m_event = 0; m_cls = 0; m_pulse = 0;
        m_pvld = 0; m_pscore = 0; m_pcls = 0;
    endtask

    task automatic model_edge();
        m_pulse = 0;
        if (m_mode == 2 && alert_ack) begin
            m_mode = 3; m_cool = 0;
        end else if (m_pvld != 0) begin
            case (m_mode)
                0: if (m_pscore >= 3) m_mode = 1;
                1: begin
                    if (m_pscore >= 3) begin
                        m_mode = 2; m_pulse = 1; m_cls = m_pcls; m_hold = 0;
                        m_event = (m_event == 255) ? 255 : m_event + 1;
                        m_entries++;
                    end else m_mode = 0;
                end
                2: begin
                    if (m_pscore <= 1) begin
                        m_hold++;
                        if (m_hold == 4) begin m_mode = 3; m_cool = 0; end
                    end else m_hold = 0;
                end
                default: begin
                    m_cool++;
                    if (m_cool == 8) m_mode = 0;
                end
            endcase
        end
        m_pvld = feature_valid;
        if (feature_valid) begin
            m_pscore = ref_score(features);
            m_pcls   = ref_class(features);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic window(input logic [127:0] f);
        features = f; feature_valid = 1'b1;
        tick();
        feature_valid = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (obs !== 19'd0) begin
            n_fail++; $display("FAIL reset_idle obs=%h exp=%h", obs, 19'd0);
        end
        window(s9());
        window(s9());
        n_tests++;
        if (obs !== exp_vec()) begin
            n_fail++; $display("FAIL pre_reset_alert obs=%h exp=%h", obs, exp_vec());
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_tests++;
        if (obs !== 19'd0) begin
            n_fail++; $display("FAIL reset_async obs=%h exp=%h", obs, 19'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        window(quiet());
        n_tests++;
        if (score !== 4'd0 || alert_level !== 2'd0 || obs !== exp_vec()) begin
            n_fail++; $display("FAIL reset_quiet obs=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_debounce();
        logic [127:0] f;
        do_reset();
        f = mk(60, 16, 200, 128, 16, 16);
        window(f);
        n_tests++;
        if (alert_level !== 2'd1 || score !== 4'd4 || obs !== exp_vec()) begin
            n_fail++; $display("FAIL debounce_armed obs=%h exp=%h", obs, exp_vec());
        end
        features = f; feature_valid = 1'b1;
        tick();
        feature_valid = 1'b0;
        n_tests++;
        if (alert_pulse !== 1'b0 || obs !== exp_vec()) begin
            n_fail++; $display("FAIL debounce_n1 obs=%h exp=%h", obs, exp_vec());
        end
        tick();
        n_tests++;
        if (alert_pulse !== 1'b1 || alert_class !== 3'd1 || event_count !== 8'd1 ||
            alert_level !== 2'd2 || obs !== exp_vec()) begin
            n_fail++; $display("FAIL debounce_entry obs=%h exp=%h", obs, exp_vec());
        end
        tick();
        n_tests++;
        if (alert_pulse !== 1'b0 || alert_active !== 1'b1 || obs !== exp_vec()) begin
            n_fail++; $display("FAIL debounce_pulse_len obs=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_single_spike();
        int pulses = 0;
        do_reset();
        features = mk(60, 16, 200, 128, 16, 16); feature_valid = 1'b1;
        tick();
        feature_valid = 1'b0;
        tick();
        pulses += alert_pulse;
        n_tests++;
        if (alert_level !== 2'd1 || obs !== exp_vec()) begin
            n_fail++; $display("FAIL spike_armed obs=%h exp=%h", obs, exp_vec());
        end
        features = mk(0, 0, 0, 128, 0, 0); feature_valid = 1'b1;
        tick();
        pulses += alert_pulse;
        feature_valid = 1'b0;
        tick();
        pulses += alert_pulse;
        n_tests++;
        if (alert_level !== 2'd0 || pulses != 0 || obs !== exp_vec()) begin
            n_fail++; $display("FAIL spike_idle obs=%h exp=%h pulses=%0d", obs, exp_vec(), pulses);
        end
    endtask

    task automatic test_crit_hold_cool();
        logic [127:0] fc;
        do_reset();
        fc = mk(255, 16, 255, 128, 255, 16);
        window(fc);
        window(fc);
        n_tests++;
        if (alert_level !== 2'd3 || score !== 4'd6 || alert_class !== 3'd1 || obs !== exp_vec()) begin
            n_fail++; $display("FAIL crit_level obs=%h exp=%h", obs, exp_vec());
        end
        for (int i = 1; i <= 4; i++) begin
            window(quiet());
            n_tests++;
            if (alert_level !== ((i < 4) ? 2'd2 : 2'd0) || obs !== exp_vec()) begin
                n_fail++; $display("FAIL hold_win%0d obs=%h exp=%h", i, obs, exp_vec());
            end
        end
        for (int i = 1; i <= 8; i++) begin
            features = s9(); feature_valid = 1'b1;
            tick();
            feature_valid = 1'b0;
            n_tests++;
            if (alert_pulse !== 1'b0 || alert_level !== 2'd0 || obs !== exp_vec()) begin
                n_fail++; $display("FAIL cool_a%0d obs=%h exp=%h", i, obs, exp_vec());
            end
            tick();
            n_tests++;
            if (alert_pulse !== 1'b0 || alert_level !== 2'd0 || alert_class !== 3'd1 ||
                obs !== exp_vec()) begin
                n_fail++; $display("FAIL cool_b%0d obs=%h exp=%h", i, obs, exp_vec());
            end
        end
        window(s9());
        n_tests++;
        if (alert_level !== 2'd1 || obs !== exp_vec()) begin
            n_fail++; $display("FAIL cool_rearm obs=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_ack();
        do_reset();
        window(s9());
        window(s9());
        n_tests++;
        if (alert_active !== 1'b1 || event_count !== 8'd1 || obs !== exp_vec()) begin
            n_fail++; $display("FAIL ack_setup obs=%h exp=%h", obs, exp_vec());
        end
        features = s9(); feature_valid = 1'b1;
        tick();
        feature_valid = 1'b0; alert_ack = 1'b1;
        tick();
        alert_ack = 1'b0;
        n_tests++;
        if (alert_active !== 1'b0 || alert_level !== 2'd0 || event_count !== 8'd1 ||
            obs !== exp_vec()) begin
            n_fail++; $display("FAIL ack_collision obs=%h exp=%h", obs, exp_vec());
        end
        do_reset();
        alert_ack = 1'b1;
        window(s9());
        tick();
        alert_ack = 1'b0;
        n_tests++;
        if (alert_level !== 2'd1 || obs !== exp_vec()) begin
            n_fail++; $display("FAIL ack_ignored_armed obs=%h exp=%h", obs, exp_vec());
        end
        window(s9());
        n_tests++;
        if (alert_pulse !== 1'b1 || event_count !== 8'd1 || obs !== exp_vec()) begin
            n_fail++; $display("FAIL ack_then_entry obs=%h exp=%h", obs, exp_vec());
        end
        do_reset();
        alert_ack = 1'b1;
        window(quiet());
        alert_ack = 1'b0;
        n_tests++;
        if (obs !== exp_vec() || alert_level !== 2'd0) begin
            n_fail++; $display("FAIL ack_idle obs=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        int r;
        do_reset();
        m_entries = 0;
        feature_valid = 1'b1;
        while (m_entries < 300 && cyc < 20000) begin
            r = $urandom_range(0, 7);
            if (r <= 4)      features = s9();
            else if (r == 5) features = quiet();
            else if (r == 6) features = mk($urandom_range(0, 255), $urandom_range(0, 255),
                                            $urandom_range(0, 255), $urandom_range(0, 255),
                                            $urandom_range(0, 255), $urandom_range(0, 255));
            else             features = mk(60, 16, 200, 128, 16, 16);
            alert_ack = ($urandom_range(0, 3) == 0);
            tick();
            cyc++;
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL b2b_cycle%0d obs=%h exp=%h", cyc, obs, exp_vec());
            end
        end
        feature_valid = 1'b0; alert_ack = 1'b0;
        n_tests++;
        if (m_entries < 300 || event_count !== 8'd255) begin
            n_fail++; $display("FAIL b2b_saturate event_count=%0d exp=255 entries=%0d",
                               event_count, m_entries);
        end
    endtask

    initial begin
        rst = 1'b1; features = '0; feature_valid = 1'b0; alert_ack = 1'b0;
        model_reset();
        m_entries = 0;
        @(posedge clk); #1;
        test_reset();
        test_debounce();
        test_single_spike();
        test_crit_hold_cool();
        test_ack();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
